// File: rtl/bus_cycle_ctrl_pkg.sv
// Shared definitions for the 8051 external bus sequencer.
// The phase constants describe one 6-clk bus cycle: address/ALE, address
// hold, strobe, sample, then a recovery phase.
package mcu51_bus_pkg;

   localparam logic [2:0] PH_ALE_LAST   = 3'd1;
   localparam logic [2:0] PH_HOLD       = 3'd2;
   localparam logic [2:0] PH_STRB_FIRST = 3'd3;
   localparam logic [2:0] PH_SAMPLE     = 3'd4;
   localparam logic [2:0] PH_LAST       = 3'd5;

   typedef enum logic [1:0] {
      CMD_FETCH = 2'd0,
      CMD_DRD   = 2'd1,
      CMD_DWR   = 2'd2
   } cmd_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Fetches and MOVX reads both return a byte from the bus.
   function automatic logic is_read(input cmd_e cmd);
      return cmd != CMD_DWR;
   endfunction

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// Request/response and pin-side signals of the bus sequencer.
// slave is the sequencer's view; master is the CPU + board view.
interface bus_cycle_ctrl_if;

   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic        fetch_gnt;
   logic        data_req;
   logic        data_we;
   logic [15:0] data_addr;
   logic [7:0]  data_wdata;
   logic        data_gnt;
   logic [7:0]  rdata;
   logic        rdata_valid;
   logic        rdata_src;
   logic [7:0]  ad_out;
   logic        ad_oe;
   logic [7:0]  ad_in;
   logic [7:0]  addr_hi;
   logic        ale;
   logic        psen_n;
   logic        rd_n;
   logic        wr_n;
   logic        busy;

   modport slave (
      input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, ad_in,
      output fetch_gnt, data_gnt, rdata, rdata_valid, rdata_src,
             ad_out, ad_oe, addr_hi, ale, psen_n, rd_n, wr_n, busy
   );

   modport master (
      output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, ad_in,
      input  fetch_gnt, data_gnt, rdata, rdata_valid, rdata_src,
             ad_out, ad_oe, addr_hi, ale, psen_n, rd_n, wr_n, busy
   );

endinterface

// File: rtl/bus_cycle_ctrl_arb.sv
// bus_req_arb: fixed-priority two-way grant between code fetch and MOVX.
// Grants are only issued while the sequencer can accept a new command.
module bus_req_arb #(
   parameter int DATA_PRIO = 1
) (
   input  logic i_accept,
   input  logic i_fetch_req,
   input  logic i_data_req,
   output logic o_fetch_gnt,
   output logic o_data_gnt
);

   generate
      if (DATA_PRIO != 0) begin : g_data_first
         assign o_data_gnt  = i_accept & i_data_req;
         assign o_fetch_gnt = i_accept & i_fetch_req & ~i_data_req;
      end else begin : g_fetch_first
         assign o_fetch_gnt = i_accept & i_fetch_req;
         assign o_data_gnt  = i_accept & i_data_req & ~i_fetch_req;
      end
   endgenerate

endmodule

// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: sequences 6-clk PSEN/RD/WR cycles on the multiplexed
// 8051 address/data bus. Pin outputs are decoded from the registered
// state/phase/command, so they change only after clock edges.
// Optional build macro MCU51_IDLE_ALE_EN: free-running ALE while idle,
// with requests accepted only at the last phase so cycles stay aligned.
module bus_cycle_ctrl
   import mcu51_bus_pkg::*;
#(
   parameter int BUS_PHASES = 6,   // phase map below assumes 6
   parameter int DATA_PRIO  = 1
) (
   input  logic             clk,
   input  logic             reset,
   bus_cycle_ctrl_if.slave  bus
);

   state_e      r_state, w_state_next;
   logic [2:0]  r_phase, w_phase_next;
   cmd_e        r_cmd;
   logic [15:0] r_addr;
   logic [7:0]  r_wdata;
   logic [7:0]  r_rdata;
   logic        r_rdata_src;
   logic        w_phase_last;
   logic        w_accept;
   logic        w_fetch_gnt;
   logic        w_data_gnt;
   logic        w_take;

   assign w_phase_last = (r_phase == 3'(BUS_PHASES - 1));

`ifdef MCU51_IDLE_ALE_EN
   // The counter runs in idle too, so only the last phase accepts.
   assign w_accept = w_phase_last;
`else
   assign w_accept = (r_state == ST_IDLE) || ((r_state == ST_RUN) && w_phase_last);
`endif

   bus_req_arb #(.DATA_PRIO(DATA_PRIO)) u_arb (
      .i_accept    (w_accept),
      .i_fetch_req (bus.fetch_req),
      .i_data_req  (bus.data_req),
      .o_fetch_gnt (w_fetch_gnt),
      .o_data_gnt  (w_data_gnt)
   );

   assign w_take        = w_fetch_gnt | w_data_gnt;
   assign bus.fetch_gnt = w_fetch_gnt;
   assign bus.data_gnt  = w_data_gnt;
   assign bus.rdata     = r_rdata;
   assign bus.rdata_src = r_rdata_src;
   assign bus.addr_hi   = r_addr[15:8];

   // State and phase register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_phase <= 3'd0;
      end else begin
         r_state <= w_state_next;
         r_phase <= w_phase_next;
      end
   end

   // Next state/phase and pin decode for the current phase.
   always_comb begin
      w_state_next    = r_state;
      w_phase_next    = r_phase;
      bus.ale         = 1'b0;
      bus.psen_n      = 1'b1;
      bus.rd_n        = 1'b1;
      bus.wr_n        = 1'b1;
      bus.ad_oe       = 1'b0;
      bus.ad_out      = r_addr[7:0];
      bus.rdata_valid = 1'b0;
      bus.busy        = 1'b0;
      case (r_state)
         ST_IDLE: begin
`ifdef MCU51_IDLE_ALE_EN
            w_phase_next = w_phase_last ? 3'd0 : r_phase + 3'd1;
            bus.ale      = (r_phase <= PH_ALE_LAST);
`else
            w_phase_next = 3'd0;
`endif
            if (w_take) begin
               w_state_next = ST_RUN;
               w_phase_next = 3'd0;
            end
         end
         ST_RUN: begin
            bus.busy     = 1'b1;
            w_phase_next = r_phase + 3'd1;
            if (w_phase_last) begin
               w_phase_next = 3'd0;
               w_state_next = w_take ? ST_RUN : ST_IDLE;
            end
            bus.ale = (r_phase <= PH_ALE_LAST);
            if (r_phase <= PH_HOLD) begin
               bus.ad_oe = 1'b1;
            end else begin
               // Writes keep driving data through recovery for hold time.
               if (r_cmd == CMD_DWR) begin
                  bus.ad_oe  = 1'b1;
                  bus.ad_out = r_wdata;
               end
               if (r_phase >= PH_STRB_FIRST && r_phase <= PH_SAMPLE) begin
                  case (r_cmd)
                     CMD_FETCH: bus.psen_n = 1'b0;
                     CMD_DRD:   bus.rd_n   = 1'b0;
                     CMD_DWR:   bus.wr_n   = 1'b0;
                     default:   bus.psen_n = 1'b1;
                  endcase
               end
               if (r_phase == PH_LAST && is_read(r_cmd)) begin
                  bus.rdata_valid = 1'b1;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_phase_next = 3'd0;
         end
      endcase
   end

   // Command latch on grant; read byte capture at the end of the strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cmd       <= CMD_FETCH;
         r_addr      <= 16'h0000;
         r_wdata     <= 8'h00;
         r_rdata     <= 8'h00;
         r_rdata_src <= 1'b0;
      end else begin
         if (w_data_gnt) begin
            r_cmd   <= bus.data_we ? CMD_DWR : CMD_DRD;
            r_addr  <= bus.data_addr;
            r_wdata <= bus.data_wdata;
         end else if (w_fetch_gnt) begin
            r_cmd  <= CMD_FETCH;
            r_addr <= bus.fetch_addr;
         end
         if (r_state == ST_RUN && r_phase == PH_SAMPLE && is_read(r_cmd)) begin
            r_rdata     <= bus.ad_in;
            r_rdata_src <= (r_cmd == CMD_DRD);
         end
      end
   end

endmodule

// File: doc/bus_cycle_ctrl.md
Name: bus_cycle_ctrl

Overview:
Sequences the external multiplexed address/data bus for the 8051 core.
- Three request sources share one bus: instruction fetch (PSEN), MOVX data read (RD) and MOVX data write (WR).
- Each bus cycle is 6 clk long, so two bus cycles fit in one 12-clk machine cycle.
- Sits between the CPU datapath (PC, address and temp registers) and the data_bus/addr_bus pins. It generates ALE, PSEN_n, RD_n and WR_n, and the output enable for the bidirectional bus.

Parameters:
- BUS_PHASES, 6, clk cycles per bus cycle (fixed phase map below; only 6 is supported).
- DATA_PRIO, 1, 1 = data request beats fetch when both are pending; 0 = fetch beats data.

Ports:
- clk  in  1  oscillator clock
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  code fetch request, held until granted
- fetch_addr  in  16  code address (PC)
- fetch_gnt  out  1  request accepted this cycle
- data_req  in  1  MOVX request, held until granted
- data_we  in  1  1 = write, 0 = read
- data_addr  in  16  external data address
- data_wdata  in  8  write data
- data_gnt  out  1  request accepted this cycle
- rdata  out  8  captured read/fetch byte
- rdata_valid  out  1  one-cycle pulse when rdata is valid
- rdata_src  out  1  0 = fetch, 1 = data read
- ad_out  out  8  low address / write data onto data_bus
- ad_oe  out  1  drive enable for data_bus
- ad_in  in  8  data_bus sampled value
- addr_hi  out  8  high address onto addr_bus
- ale  out  1  address latch enable
- psen_n  out  1  program store enable, active low
- rd_n  out  1  read strobe, active low
- wr_n  out  1  write strobe, active low
- busy  out  1  a bus cycle is in progress

Behaviour:
- Reset values: ale=0, psen_n=rd_n=wr_n=1, ad_oe=0, ad_out=0, addr_hi=0, rdata=0, rdata_valid=0, rdata_src=0, busy=0. Phase counter=0, state=IDLE.
- States: IDLE, RUN. In RUN, phase counts 0..5.
- Accept window: state==IDLE, or RUN with phase==5.
- Grants: gnt is combinational from registered state and the req inputs. At most one gnt per cycle; the winner is chosen by DATA_PRIO.
- On the accept edge the block latches the command (FETCH/DRD/DWR), address and wdata. The next cycle is phase 0.
- Phase 0-1: ale=1, ad_oe=1, ad_out=addr[7:0], addr_hi=addr[15:8].
- Phase 2: ale=0; address held on ad_out with ad_oe=1.
- Phase 3-4, FETCH/DRD: ad_oe=0, psen_n=0 (FETCH) or rd_n=0 (DRD).
- Phase 3-4, DWR: ad_out=wdata, ad_oe=1, wr_n=0.
- End of phase 4: ad_in is captured into rdata (reads only).
- Phase 5: all strobes =1.
  - Reads: rdata_valid=1 and rdata_src set.
  - DWR: ad_oe stays 1 with wdata held (data hold time).
- Phase 5 with no accepted request: return to IDLE, ad_oe=0.
- Phase 5 with an accepted request: back-to-back cycle, the next cycle is phase 0. No idle gap.
- Latency: rdata_valid rises exactly 6 cycles after the grant cycle.
- addr_hi holds its last value between cycles.
- busy=1 in RUN.
- Simultaneous requests: the loser's req stays high and is granted at the next accept window. No request is dropped.
- Reset asserted mid-cycle: the next edge forces reset values and discards the cycle. No rdata_valid is produced and strobes return high immediately.
- A req deasserted without a gnt is legal and ignored.

Optional Feature:
- Macro: MCU51_IDLE_ALE_EN
- Defined: in IDLE the phase counter free-runs 0..5. ale pulses in phases 0-1 with no strobe and ad_oe=0, emulating the 8051 free-running ALE. Requests are accepted only at phase 5, so bus cycles stay phase-aligned; worst-case grant wait is 6 clk.
- Undefined: the counter is held at 0 in IDLE, ale=0, and a request is accepted in any IDLE cycle.

Decomposition:
- Package mcu51_bus_pkg holds:
  - phase constants PH_ALE_LAST=1, PH_HOLD=2, PH_STRB_FIRST=3, PH_SAMPLE=4, PH_LAST=5;
  - command enum CMD_FETCH/CMD_DRD/CMD_DWR;
  - state enum ST_IDLE/ST_RUN.
- One sub-module is natural: bus_req_arb, a fixed-priority two-way grant honouring DATA_PRIO and the accept window.

Test Plan:
- Fetch 0x1234 with ad_in=0xA5 -> ale high 2 clk; ad_out=0x34, addr_hi=0x12 in phases 0-2; psen_n low phases 3-4; rdata=0xA5, rdata_valid, rdata_src=0 at grant+6.
- Data write 0x00F0 with wdata 0x5C -> wr_n low 2 clk; ad_out=0x5C, ad_oe=1 in phases 3-5; rd_n and psen_n stay 1; no rdata_valid.
- fetch_req and data_req (read) raised together, DATA_PRIO=1 -> data_gnt first, fetch_gnt at the phase-5 edge; two contiguous 6-clk cycles; 12 clk total.
- Back-to-back fetches 0x0100, 0x0101 -> no IDLE cycle between; ale pulses at clk 0 and 6.
- reset asserted in phase 3 of a read -> next cycle rd_n=1, ad_oe=0, busy=0; no rdata_valid.
- With MCU51_IDLE_ALE_EN, idle for 24 clk -> 4 ale pulses of 2 clk each; a request raised at phase 2 is granted at phase 5.
